// File: rtl/ggt_pkg.sv
// Shared types and default sizes for the binary GCD engine (ggt_binaer).
package ggt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ggt_state_t;

    localparam int GGT_WIDTH_DEF = 16;
    localparam int GGT_CNT_W_DEF = 8;

    // Width of the common power-of-two counter k for a given operand width.
    function automatic int ggt_k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/ggt_schritt.sv
// One combinational Stein step: reduces (a, b) towards equality while tracking
// the shared factor of two in k; fertig flags that a == b.
module ggt_schritt #(
    parameter int WIDTH = 16,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_nx,
    output logic [WIDTH-1:0] b_nx,
    output logic [KW-1:0]    k_nx,
    output logic             fertig
);

    always_comb begin
        a_nx   = a;
        b_nx   = b;
        k_nx   = k;
        fertig = 1'b0;
        if (a == b) begin
            fertig = 1'b1;
        end else if (!a[0] && !b[0]) begin
            a_nx = a >> 1;
            b_nx = b >> 1;
            k_nx = k + KW'(1);
        end else if (!a[0]) begin
            a_nx = a >> 1;
        end else if (!b[0]) begin
            b_nx = b >> 1;
        end else if (a > b) begin
            // Difference of two odd numbers is even, so the halving is exact.
            a_nx = (a - b) >> 1;
        end else begin
            b_nx = (b - a) >> 1;
        end
    end

endmodule

// File: rtl/ggt_binaer.sv
// Parametrised binary (Stein) GCD engine: IDLE -> CALC (one reduction per cycle)
// -> DONE, with zero operands short-circuited straight to DONE.
module ggt_binaer
    import ggt_pkg::*;
#(
    parameter int WIDTH = GGT_WIDTH_DEF,
    parameter int CNT_W = GGT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic [WIDTH-1:0] ergebnis,
    output logic             valid,
    output logic             busy,
    output logic [CNT_W-1:0] schritte,
    output ggt_state_t       state_dbg
);

    // Handshake: start_i is accepted only in IDLE (operands sampled on that edge);
    // busy stays high until the single-cycle valid pulse ends; ergebnis and
    // schritte are stable from the valid cycle until the next accepted start.

    localparam int KW = ggt_k_width(WIDTH);

    ggt_state_t       state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, a_nx, b_nx, a_st, b_st, erg_nx;
    logic [KW-1:0]    k_q, k_nx, k_st;
    logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc, schr_nx;
    logic             fertig;

    ggt_schritt #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_schritt (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .a_nx   (a_st),
        .b_nx   (b_st),
        .k_nx   (k_st),
        .fertig (fertig)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        k_nx     = k_q;
        cnt_nx   = cnt_q;
        erg_nx   = ergebnis;
        schr_nx  = schritte;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (Zahl1_i == '0 || Zahl2_i == '0) begin
                        erg_nx   = (Zahl1_i == '0) ? Zahl2_i : Zahl1_i;
                        schr_nx  = '0;
                        state_nx = DONE;
                    end else begin
                        a_nx     = Zahl1_i;
                        b_nx     = Zahl2_i;
                        k_nx     = '0;
                        cnt_nx   = '0;
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                cnt_nx = cnt_inc;
                if (fertig) begin
                    // Result never exceeds min(a,b) of the inputs, so the shift cannot overflow.
                    erg_nx   = a_q << k_q;
                    schr_nx  = cnt_inc;
                    state_nx = DONE;
                end else begin
                    a_nx = a_st;
                    b_nx = b_st;
                    k_nx = k_st;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            ergebnis <= '0;
            schritte <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            k_q      <= k_nx;
            cnt_q    <= cnt_nx;
            ergebnis <= erg_nx;
            schritte <= schr_nx;
            valid    <= (state_nx == DONE);
            busy     <= (state_nx != IDLE);
        end
    end

endmodule
